ds18b20_seq: RTL and testbench

Sequencer that drives the `one_wire` byte engine through a complete DS18B20 temperature acquisition: reset/presence, Skip ROM, Convert T, conversion polling, reset, Skip ROM, Read Scratchpad, 9-byte readback and CRC-8 check. It sits between the SPI command decoder and `one_wire`, and is the only block driving the engine's strobes while it is busy. It returns a 16-bit raw temperature and a status code.

---
 rtl/onewire_pkg.sv | 48 ++++
 rtl/crc8_dallas.sv | 38 +++
 rtl/ds18b20_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ds18b20_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the DS18B20 acquisition sequencer.
//   - Sequencer main states and engine sub-phases
//   - 1-wire command bytes, status codes, CRC polynomial
//   - crc8_step(): one reflected Dallas CRC-8 step (x^8+x^5+x^4+1)
package onewire_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRst1,
    StSkip1,
    StConv,
    StGap,
    StPoll,
    StRst2,
    StSkip2,
    StRdCmd,
    StRd8,
    StRd1,
    StCheck,
    StDone
  } state_e;

  // Every engine operation walks these three phases.
  typedef enum logic [1:0] {
    PhIssue,
    PhWaitStart,
    PhWaitEnd
  } phase_e;

  localparam logic [7:0] SkipRom  = 8'hCC;
  localparam logic [7:0] ConvertT = 8'h44;
  localparam logic [7:0] ReadSp   = 8'hBE;

  localparam logic [1:0] StatusOk      = 2'd0;
  localparam logic [1:0] StatusNoPres  = 2'd1;
  localparam logic [1:0] StatusCrcErr  = 2'd2;
  localparam logic [1:0] StatusTimeout = 2'd3;

  localparam logic [7:0] CrcPoly = 8'h8C;

  // One bit of the LSB-first Dallas CRC.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic din);
    logic fb;
    fb = crc_in[0] ^ din;
    return (crc_in >> 1) ^ (fb ? CrcPoly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_dallas.sv
// Serial Dallas CRC-8, one data bit per enabled cycle.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force CRC to 0x00 (wins over en)
//   en, din  : shift din into the CRC this cycle
//   crc      : current CRC register
module crc8_dallas
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ds18b20_seq.sv
// DS18B20 temperature acquisition sequencer driving the one_wire byte engine.
//   start            : one-cycle acquisition request (ignored while busy)
//   busy, done       : activity flag and one-cycle completion pulse
//   status, temp     : result code (held until next done), raw temperature
//   ow_reset/write/read, ow_in_byte, ow_start_bit/end_bit : engine strobes + args
//   ow_busy, ow_presence, ow_out : engine status and read data
module ds18b20_seq
  import onewire_pkg::*;
#(
  parameter int unsigned POLL_GAP   = 100000,
  parameter int unsigned MAX_POLLS  = 1000,
  parameter int unsigned START_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] temp,
  output logic        ow_reset,
  output logic        ow_write,
  output logic        ow_read,
  output logic [7:0]  ow_in_byte,
  output logic [5:0]  ow_start_bit,
  output logic [5:0]  ow_end_bit,
  input  logic        ow_busy,
  input  logic        ow_presence,
  input  logic [63:0] ow_out
);

  localparam int unsigned GapW  = $clog2(POLL_GAP + 1);
  localparam int unsigned PollW = $clog2(MAX_POLLS + 1);
  localparam int unsigned WaitW = $clog2(START_WAIT + 1);

  state_e            state_d, state_q;
  phase_e            phase_d, phase_q;
  logic [GapW-1:0]   gap_cnt_d, gap_cnt_q;
  logic [PollW-1:0]  poll_cnt_d, poll_cnt_q;
  logic [WaitW-1:0]  wait_cnt_d, wait_cnt_q;
  logic [5:0]        chk_cnt_d, chk_cnt_q;
  logic [63:0]       sp_d, sp_q;
  logic [7:0]        crc_rx_d, crc_rx_q;
  logic [1:0]        status_d, status_q;
  logic [15:0]       temp_d, temp_q;

  logic              op_done;
  logic              crc_clr, crc_en;
  logic [7:0]        crc_val;

  crc8_dallas u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (sp_q[chk_cnt_q]),
    .crc (crc_val)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    gap_cnt_d    = gap_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    sp_d         = sp_q;
    crc_rx_d     = crc_rx_q;
    status_d     = status_q;
    temp_d       = temp_q;
    ow_reset     = 1'b0;
    ow_write     = 1'b0;
    ow_read      = 1'b0;
    ow_in_byte   = 8'h00;
    ow_start_bit = 6'd0;
    ow_end_bit   = 6'd0;
    done         = 1'b0;
    crc_clr      = 1'b1;
    crc_en       = 1'b0;
    op_done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRst1;
          phase_d    = PhIssue;
          poll_cnt_d = '0;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapW'(POLL_GAP - 1)) begin
          gap_cnt_d = '0;
          phase_d   = PhIssue;
          // Counter already holds the number of failed polls; no wrap possible.
          if (poll_cnt_q == PollW'(MAX_POLLS)) begin
            state_d  = StDone;
            status_d = StatusTimeout;
          end else begin
            state_d = StPoll;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      StCheck: begin
        crc_clr   = 1'b0;
        crc_en    = 1'b1;
        chk_cnt_d = chk_cnt_q + 6'd1;
        if (chk_cnt_q == 6'd63) begin
          // Fold in the final bit here so status is ready in the DONE cycle.
          state_d = StDone;
          if (crc8_step(crc_val, sp_q[63]) == crc_rx_q) begin
            status_d = StatusOk;
            temp_d   = sp_q[15:0];
          end else begin
            status_d = StatusCrcErr;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        unique case (phase_q)
          PhIssue: begin
            // Hold off if the engine is still finishing work from before a reset.
            if (!ow_busy) begin
              phase_d    = PhWaitStart;
              wait_cnt_d = '0;
              unique case (state_q)
                StRst1, StRst2: ow_reset = 1'b1;
                StSkip1, StSkip2: begin
                  ow_write   = 1'b1;
                  ow_in_byte = SkipRom;
                  ow_end_bit = 6'd7;
                end
                StConv: begin
                  ow_write   = 1'b1;
                  ow_in_byte = ConvertT;
                  ow_end_bit = 6'd7;
                end
                StRdCmd: begin
                  ow_write   = 1'b1;
                  ow_in_byte = ReadSp;
                  ow_end_bit = 6'd7;
                end
                StPoll: begin
                  ow_read      = 1'b1;
                  ow_start_bit = 6'd63;
                  ow_end_bit   = 6'd63;
                end
                StRd8: begin
                  ow_read      = 1'b1;
                  ow_start_bit = 6'd0;
                  ow_end_bit   = 6'd63;
                end
                StRd1: begin
                  ow_read      = 1'b1;
                  ow_start_bit = 6'd56;
                  ow_end_bit   = 6'd63;
                end
                default: ;
              endcase
            end
          end
          PhWaitStart: begin
            if (ow_busy) begin
              phase_d = PhWaitEnd;
            end else if (wait_cnt_q == WaitW'(START_WAIT)) begin
              state_d  = StDone;
              phase_d  = PhIssue;
              status_d = StatusTimeout;
            end else begin
              wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
          end
          PhWaitEnd: begin
            if (!ow_busy) begin
              op_done = 1'b1;
            end
          end
          default: phase_d = PhIssue;
        endcase
      end
    endcase

    if (op_done) begin
      phase_d = PhIssue;
      unique case (state_q)
        StRst1, StRst2: begin
          if (!ow_presence) begin
            state_d  = StDone;
            status_d = StatusNoPres;
          end else begin
            state_d = (state_q == StRst1) ? StSkip1 : StSkip2;
          end
        end
        StSkip1: state_d = StConv;
        StConv: begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end
        StPoll: begin
          if (ow_out[63]) begin
            state_d = StRst2;
          end else begin
            state_d    = StGap;
            gap_cnt_d  = '0;
            poll_cnt_d = poll_cnt_q + PollW'(1);
          end
        end
        StSkip2: state_d = StRdCmd;
        StRdCmd: state_d = StRd8;
        StRd8: begin
          sp_d    = ow_out;
          state_d = StRd1;
        end
        StRd1: begin
          crc_rx_d  = ow_out[63:56];
          chk_cnt_d = 6'd0;
          state_d   = StCheck;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= PhIssue;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
      chk_cnt_q  <= 6'd0;
      sp_q       <= 64'h0;
      crc_rx_q   <= 8'h00;
      status_q   <= StatusOk;
      temp_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      sp_q       <= sp_d;
      crc_rx_q   <= crc_rx_d;
      status_q   <= status_d;
      temp_q     <= temp_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign status = status_q;
  assign temp   = temp_q;

endmodule

// File: tb/tb_ds18b20_seq.sv
// Self-checking bench for ds18b20_seq with a behavioural one_wire engine model.
module tb_ds18b20_seq;

  localparam int unsigned PollGap   = 10;
  localparam int unsigned MaxPolls  = 5;
  localparam int unsigned StartWait = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] temp;
  logic        ow_reset, ow_write, ow_read;
  logic [7:0]  ow_in_byte;
  logic [5:0]  ow_start_bit, ow_end_bit;
  logic        ow_busy, ow_presence;
  logic [63:0] ow_out;

  always #5 clk = ~clk;

  ds18b20_seq #(
    .POLL_GAP   (PollGap),
    .MAX_POLLS  (MaxPolls),
    .START_WAIT (StartWait)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .temp         (temp),
    .ow_reset     (ow_reset),
    .ow_write     (ow_write),
    .ow_read      (ow_read),
    .ow_in_byte   (ow_in_byte),
    .ow_start_bit (ow_start_bit),
    .ow_end_bit   (ow_end_bit),
    .ow_busy      (ow_busy),
    .ow_presence  (ow_presence),
    .ow_out       (ow_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine model ----------------
  logic        dead = 1'b0;
  logic        pres_cfg = 1'b1;
  logic [63:0] sp_cfg = 64'h100C_FF7F_464B_0550;
  logic [7:0]  crc_cfg = 8'h1C;
  logic        poll_default = 1'b0;
  logic        poll_q[$];

  logic        eng_busy = 1'b0;
  logic        eng_pres = 1'b0;
  logic [63:0] eng_out = 64'h0;
  int          bcnt = 0;
  logic [3:0]  op_kind = 4'h0;
  logic        prev_strobe = 1'b0;
  int          proto_err = 0;
  longint      cyc = 0;
  longint      strobe_cyc = 0;
  longint      done_cyc = 0;
  logic [11:0] log_q[$];       // {kind, byte}: 1 reset, 2 write, 3 poll, 4 read8, 5 read1
  longint      poll_cyc_q[$];
  logic [11:0] entry_now;
  logic        strobe_any;

  assign ow_busy     = eng_busy;
  assign ow_presence = eng_pres;
  assign ow_out      = eng_out;
  assign strobe_any  = ow_reset | ow_write | ow_read;

  always_comb begin
    entry_now = 12'hF00;
    if (ow_reset) begin
      entry_now = 12'h100;
    end else if (ow_write) begin
      entry_now = {4'h2, ow_in_byte};
    end else if (ow_read) begin
      if (ow_start_bit == 6'd63 && ow_end_bit == 6'd63) entry_now = 12'h300;
      else if (ow_start_bit == 6'd0 && ow_end_bit == 6'd63) entry_now = 12'h400;
      else if (ow_start_bit == 6'd56 && ow_end_bit == 6'd63) entry_now = 12'h500;
    end
  end

  function automatic logic next_poll();
    if (poll_q.size() != 0) return poll_q.pop_front();
    return poll_default;
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    prev_strobe <= strobe_any;
    if (strobe_any) begin
      if (eng_busy || prev_strobe || ($countones({ow_reset, ow_write, ow_read}) > 1))
        proto_err <= proto_err + 1;
      log_q.push_back(entry_now);
      if (entry_now == 12'h300) poll_cyc_q.push_back(cyc);
      strobe_cyc <= cyc;
      op_kind    <= entry_now[11:8];
      if (!dead) begin
        eng_busy <= 1'b1;
        bcnt     <= 3;
      end
    end else if (eng_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        eng_busy <= 1'b0;
        case (op_kind)
          4'h1: eng_pres <= pres_cfg;
          4'h3: eng_out <= {next_poll(), 63'h0};
          4'h4: eng_out <= sp_cfg;
          4'h5: eng_out <= {crc_cfg, 56'h0};
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];       // {status, temp}
  int          done_total = 0;

  always @(negedge clk) begin
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
      check("done_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("status", status, exp_q[0][17:16]);
        check("temp", temp, exp_q[0][15:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic start_acq();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("reset_after_start", ow_reset, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int base;
    int n;
    base = done_total;
    n = 0;
    while (done_total == base && n < bound) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_total != base, 1'b1);
    if (done_total == base) exp_q.delete();
  endtask

  task automatic run_acq(input string tag, input logic [1:0] st, input logic [15:0] t);
    log_q.delete();
    poll_cyc_q.delete();
    exp_q.push_back({st, t});
    start_acq();
    wait_done(tag, 3000);
  endtask

  function automatic int count_kind(input logic [3:0] k);
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i][11:8] == k) c++;
    return c;
  endfunction

  logic [11:0] exp_log [9];
  int          base_done;
  int          n;

  initial begin
    exp_log = '{12'h100, 12'h2CC, 12'h244, 12'h300, 12'h100, 12'h2CC, 12'h2BE, 12'h400, 12'h500};
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'd0);
    check("rst_temp", temp, 16'h0);
    check("rst_strobes", {ow_reset, ow_write, ow_read, ow_in_byte, ow_start_bit, ow_end_bit}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Good scratchpad
    poll_q.push_back(1'b1);
    run_acq("good", 2'd0, 16'h0550);
    check("good_log_len", log_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < log_q.size()) check($sformatf("good_log%0d", i), log_q[i], exp_log[i]);
    end

    // No device
    pres_cfg = 1'b0;
    run_acq("nodev", 2'd1, 16'h0550);
    check("nodev_writes", count_kind(4'h2), 0);
    check("nodev_log_len", log_q.size(), 1);
    pres_cfg = 1'b1;

    // Corrupt CRC
    crc_cfg = 8'h1D;
    poll_q.push_back(1'b1);
    run_acq("badcrc", 2'd2, 16'h0550);
    crc_cfg = 8'h1C;

    // Slow conversion
    poll_q.push_back(1'b0);
    poll_q.push_back(1'b0);
    poll_q.push_back(1'b0);
    poll_q.push_back(1'b1);
    run_acq("slow", 2'd0, 16'h0550);
    check("slow_polls", count_kind(4'h3), 4);
    for (int i = 1; i < poll_cyc_q.size(); i++) begin
      check($sformatf("slow_gap%0d", i), (poll_cyc_q[i] - poll_cyc_q[i-1]) >= PollGap, 1'b1);
    end

    // Conversion never completes
    poll_q.delete();
    poll_default = 1'b0;
    run_acq("timeout", 2'd3, 16'h0550);
    check("timeout_polls", count_kind(4'h3), MaxPolls);
    check("timeout_resets", count_kind(4'h1), 1);

    // Dead engine
    dead = 1'b1;
    run_acq("dead", 2'd3, 16'h0550);
    check("dead_latency", done_cyc - strobe_cyc, StartWait + 2);
    repeat (20) @(posedge clk);
    #1;
    check("dead_log_len", log_q.size(), 1);
    check("dead_strobes_idle", {ow_reset, ow_write, ow_read}, 3'b000);
    dead = 1'b0;

    // Reset during RD8
    poll_q.push_back(1'b1);
    log_q.delete();
    start_acq();
    n = 0;
    while (count_kind(4'h4) == 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("rd8_reached", count_kind(4'h4), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_outputs", {busy, done, status, temp, ow_reset, ow_write, ow_read,
                             ow_in_byte, ow_start_bit, ow_end_bit}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Restart after reset, with a stray start while busy
    base_done = done_total;
    poll_q.push_back(1'b1);
    log_q.delete();
    exp_q.push_back({2'd0, 16'h0550});
    start_acq();
    repeat (20) @(posedge clk);
    #1;
    check("busy_before_stray_start", busy, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart", 3000);
    check("restart_first_op", (log_q.size() != 0) ? log_q[0] : 12'hFFF, 12'h100);
    repeat (400) @(posedge clk);
    check("single_done", done_total - base_done, 1);

    check("engine_protocol", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
